// File: rtl/hilo_disp_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : hilo_disp_scan_if
// Brief   : Digit, control and display signals of the HI/LO display scanner.
// Revision: 1.0 - initial release
// ============================================================================
interface hilo_disp_scan_if;
    logic [3:0] HW_dig3;
    logic [3:0] HW_dig2;
    logic [3:0] HW_dig1;
    logic [3:0] HW_dig0;
    logic       auto_en;
    logic       hilo_btn;
    logic       blank_lz;
    logic       HILO_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output HW_dig3, HW_dig2, HW_dig1, HW_dig0,
        output auto_en, hilo_btn, blank_lz,
        input  HILO_sel, an, seg, dp, frame_tick
    );

    modport slave (
        input  HW_dig3, HW_dig2, HW_dig1, HW_dig0,
        input  auto_en, hilo_btn, blank_lz,
        output HILO_sel, an, seg, dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/hilo_disp_scan.sv
`default_nettype none
// ============================================================================
// Module  : hilo_disp_scan
// Brief   : Four-digit seven-segment scanner with frame snapshot and HI/LO select.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_disp_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int HILO_FRAMES = 256
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hilo_disp_scan_if.slave  bus
);

    localparam int c_PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_FCNT_W = (HILO_FRAMES > 1) ? $clog2(HILO_FRAMES) : 1;
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(REFRESH_DIV - 1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_MAX = c_FCNT_W'(HILO_FRAMES - 1);

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [1:0]          r_idx;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [3:0]          r_snap [4];
    logic                r_btn;
    logic                r_hilo_sel;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_tick;

    logic                w_tick;
    logic                w_frame_end;
    logic                w_btn_rise;
    logic                w_auto_hit;
    logic [3:0]          w_blank;
    logic [3:0]          w_digit;
    logic [6:0]          w_seg;

    assign w_tick      = (r_pcnt == c_PCNT_MAX);
    assign w_frame_end = w_tick && (r_idx == 2'd3);
    assign w_btn_rise  = bus.hilo_btn && !r_btn;
    assign w_auto_hit  = w_frame_end && bus.auto_en && (r_fcnt == c_FCNT_MAX);

    // A digit is blanked only when it and every more significant digit are zero.
    assign w_blank[3] = bus.blank_lz && (r_snap[3] == 4'h0);
    assign w_blank[2] = w_blank[3] && (r_snap[2] == 4'h0);
    assign w_blank[1] = w_blank[2] && (r_snap[1] == 4'h0);
    assign w_blank[0] = 1'b0;

    assign w_digit = r_snap[r_idx];

    always_comb begin
        w_seg = 7'b1111111;
        case (w_digit)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            4'hF: w_seg = 7'b0001110;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_idx        <= 2'd0;
            r_fcnt       <= '0;
            r_snap[0]    <= 4'h0;
            r_snap[1]    <= 4'h0;
            r_snap[2]    <= 4'h0;
            r_snap[3]    <= 4'h0;
            r_btn        <= 1'b0;
            r_hilo_sel   <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_frame_end) begin
                r_snap[0] <= bus.HW_dig0;
                r_snap[1] <= bus.HW_dig1;
                r_snap[2] <= bus.HW_dig2;
                r_snap[3] <= bus.HW_dig3;
            end
            r_frame_tick <= w_frame_end;

            // Button edge and auto toggle in the same cycle merge into one toggle.
            r_btn <= bus.hilo_btn;
            if (w_btn_rise || w_auto_hit) begin
                r_hilo_sel <= !r_hilo_sel;
            end

            if (!bus.auto_en || w_btn_rise || w_auto_hit) begin
                r_fcnt <= '0;
            end else if (w_frame_end) begin
                r_fcnt <= r_fcnt + 1'b1;
            end

            if (w_blank[r_idx]) begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
            end else begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_seg;
            end
            r_dp <= !((r_idx == 2'd3) && r_hilo_sel);
        end
    end

    assign bus.HILO_sel   = r_hilo_sel;
    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_hilo_disp_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_disp_scan
// Brief   : Directed self-checking bench for hilo_disp_scan (REFRESH_DIV=4, HILO_FRAMES=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_hilo_disp_scan;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    hilo_disp_scan_if u_if ();

    hilo_disp_scan #(
        .REFRESH_DIV (4),
        .HILO_FRAMES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cyc numbers the intervals after reset release; sampling sits 1 time unit past each edge.
    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic set_dig(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        u_if.HW_dig3 = d3;
        u_if.HW_dig2 = d2;
        u_if.HW_dig1 = d1;
        u_if.HW_dig0 = d0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        set_dig(4'h4, 4'h3, 4'h2, 4'h1);
        u_if.auto_en  = 1'b0;
        u_if.hilo_btn = 1'b0;
        u_if.blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an",   8'(u_if.an), 8'h0F);
        check("rst_seg",  8'(u_if.seg), 8'h7F);
        check("rst_dp",   8'(u_if.dp), 8'h01);
        check("rst_sel",  8'(u_if.HILO_sel), 8'h00);
        check("rst_tick", 8'(u_if.frame_tick), 8'h00);

        // Frame 1 shows the reset snapshot, then 1,2,3,4 appears.
        rst = 1'b0;
        cyc = 0;
        wait_to(1);
        check("f1_an0",  8'(u_if.an), 8'h0E);
        check("f1_seg0", 8'(u_if.seg), 8'h40);
        check("f1_dp",   8'(u_if.dp), 8'h01);
        wait_to(5);
        check("f1_an1",  8'(u_if.an), 8'h0D);
        check("f1_seg1", 8'(u_if.seg), 8'h40);
        wait_to(15);
        check("tick_pre", 8'(u_if.frame_tick), 8'h00);
        wait_to(16);
        check("tick_on", 8'(u_if.frame_tick), 8'h01);
        check("f1_an3",  8'(u_if.an), 8'h07);
        wait_to(17);
        check("tick_off", 8'(u_if.frame_tick), 8'h00);
        check("f2_an0",  8'(u_if.an), 8'h0E);
        check("f2_seg0", 8'(u_if.seg), 8'h79);

        // Mid-frame input change must not reach the current frame.
        wait_to(18);
        set_dig(4'h6, 4'hF, 4'hA, 4'h8);
        wait_to(20);
        check("f2_seg0_hold", 8'(u_if.seg), 8'h79);
        wait_to(21);
        check("f2_an1",  8'(u_if.an), 8'h0D);
        check("f2_seg1", 8'(u_if.seg), 8'h24);
        wait_to(25);
        check("f2_an2",  8'(u_if.an), 8'h0B);
        check("f2_seg2", 8'(u_if.seg), 8'h30);
        wait_to(29);
        check("f2_an3",  8'(u_if.an), 8'h07);
        check("f2_seg3", 8'(u_if.seg), 8'h19);
        wait_to(32);
        check("f2_tick", 8'(u_if.frame_tick), 8'h01);
        check("f2_seg3_end", 8'(u_if.seg), 8'h19);
        wait_to(33);
        check("f3_seg0", 8'(u_if.seg), 8'h00);
        wait_to(37);
        check("f3_seg1", 8'(u_if.seg), 8'h08);
        wait_to(41);
        check("f3_seg2", 8'(u_if.seg), 8'h0E);
        wait_to(45);
        check("f3_seg3", 8'(u_if.seg), 8'h02);
        check("f3_dp",   8'(u_if.dp), 8'h01);

        // Automatic toggle after two frame ends.
        wait_to(46);
        u_if.auto_en = 1'b1;
        wait_to(63);
        check("auto_pre", 8'(u_if.HILO_sel), 8'h00);
        wait_to(64);
        check("auto_on",  8'(u_if.HILO_sel), 8'h01);
        check("dp_64",    8'(u_if.dp), 8'h01);
        wait_to(76);
        check("dp_76",    8'(u_if.dp), 8'h01);
        wait_to(77);
        check("dp_77",    8'(u_if.dp), 8'h00);
        wait_to(80);
        check("dp_80",    8'(u_if.dp), 8'h00);
        check("sel_80",   8'(u_if.HILO_sel), 8'h01);
        wait_to(81);
        check("dp_81",    8'(u_if.dp), 8'h01);
        wait_to(96);
        check("auto_off", 8'(u_if.HILO_sel), 8'h00);

        // Manual button held for 10 cycles: one toggle, frame counter cleared.
        wait_to(114);
        check("btn_pre", 8'(u_if.HILO_sel), 8'h00);
        u_if.hilo_btn = 1'b1;
        wait_to(115);
        check("btn_tog", 8'(u_if.HILO_sel), 8'h01);
        wait_to(124);
        check("btn_hold", 8'(u_if.HILO_sel), 8'h01);
        u_if.hilo_btn = 1'b0;
        wait_to(128);
        check("btn_fclr", 8'(u_if.HILO_sel), 8'h01);
        wait_to(143);
        check("auto2_pre", 8'(u_if.HILO_sel), 8'h01);
        wait_to(144);
        check("auto2_tog", 8'(u_if.HILO_sel), 8'h00);

        // Button edge on the auto-toggle frame end: a single toggle.
        wait_to(175);
        check("coin_pre", 8'(u_if.HILO_sel), 8'h00);
        u_if.hilo_btn = 1'b1;
        wait_to(176);
        check("coin_tog", 8'(u_if.HILO_sel), 8'h01);
        wait_to(180);
        u_if.hilo_btn = 1'b0;
        wait_to(192);
        check("coin_fclr", 8'(u_if.HILO_sel), 8'h01);

        // Leading-zero blanking.
        wait_to(193);
        u_if.auto_en  = 1'b0;
        u_if.blank_lz = 1'b1;
        set_dig(4'h0, 4'h0, 4'h5, 4'h0);
        wait_to(209);
        check("lz_an0",  8'(u_if.an), 8'h0E);
        check("lz_seg0", 8'(u_if.seg), 8'h40);
        wait_to(213);
        check("lz_an1",  8'(u_if.an), 8'h0D);
        check("lz_seg1", 8'(u_if.seg), 8'h12);
        wait_to(217);
        check("lz_an2",  8'(u_if.an), 8'h0F);
        wait_to(221);
        check("lz_an3",  8'(u_if.an), 8'h0F);
        check("lz_dp3",  8'(u_if.dp), 8'h00);
        wait_to(222);
        set_dig(4'h0, 4'h0, 4'h0, 4'h0);
        wait_to(225);
        check("z_an0",  8'(u_if.an), 8'h0E);
        check("z_seg0", 8'(u_if.seg), 8'h40);
        wait_to(229);
        check("z_an1",  8'(u_if.an), 8'h0F);
        wait_to(233);
        check("z_an2",  8'(u_if.an), 8'h0F);
        wait_to(237);
        check("z_an3",  8'(u_if.an), 8'h0F);

        // Mid-frame reset with HILO_sel=1.
        wait_to(238);
        u_if.blank_lz = 1'b0;
        set_dig(4'h4, 4'h3, 4'h2, 4'h1);
        wait_to(241);
        check("pre_rst_seg", 8'(u_if.seg), 8'h79);
        check("pre_rst_sel", 8'(u_if.HILO_sel), 8'h01);
        wait_to(245);
        rst = 1'b1;
        wait_to(246);
        check("mrst_sel", 8'(u_if.HILO_sel), 8'h00);
        check("mrst_an",  8'(u_if.an), 8'h0F);
        check("mrst_seg", 8'(u_if.seg), 8'h7F);
        check("mrst_dp",  8'(u_if.dp), 8'h01);
        check("mrst_tick", 8'(u_if.frame_tick), 8'h00);
        rst = 1'b0;
        cyc = 0;
        wait_to(1);
        check("mrst_an0",  8'(u_if.an), 8'h0E);
        check("mrst_snap", 8'(u_if.seg), 8'h40);
        wait_to(17);
        check("mrst_f2", 8'(u_if.seg), 8'h79);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
